// File: rtl/score_event_gen_pkg.sv
// Shared types and widths for the pong score path (anim_gen, sync_mod, score_event_gen).
package score_event_gen_pkg;

  localparam int unsigned Y_W     = 10;
  localparam int unsigned SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    SCORED,
    HOLDOFF,
    WAIT_SERVE,
    GAME_OVER
  } ref_state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

endpackage

// File: rtl/score_event_gen_if.sv
// Score-pulse interface between the animation/frame source, score_event_gen and the score counters.
interface score_event_gen_if
  import score_event_gen_pkg::*;
();

  logic           frame_tick;
  logic [Y_W-1:0] ball_y;
  logic           serve_btn;
  logic           score1_pulse;
  logic           score2_pulse;
  logic           ball_freeze;
  logic           serve_dir;
  logic           game_over;
  logic           winner;
  logic           match_clear;

  // Producer (score_event_gen) side
  modport master (
    input  frame_tick, ball_y, serve_btn,
    output score1_pulse, score2_pulse, ball_freeze, serve_dir, game_over, winner, match_clear
  );

  // Consumer (frame source / score counters) side
  modport slave (
    output frame_tick, ball_y, serve_btn,
    input  score1_pulse, score2_pulse, ball_freeze, serve_dir, game_over, winner, match_clear
  );

endinterface

// File: rtl/score_event_gen_btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser plus registered rising-edge pulse for an asynchronous button.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  // A level-held button yields exactly one pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/score_event_gen.sv
// Goal detector / score-pulse producer with post-goal hold-off, serve handling and match end.
// Optional SCORE_AUTOSERVE_EN: WAIT_SERVE also exits to PLAY after SERVE_TO_FRAMES frame ticks.
module score_event_gen
  import score_event_gen_pkg::*;
#(
  parameter int unsigned TOP_GOAL_Y      = 10,
  parameter int unsigned BOTTOM_GOAL_Y   = 470,
  parameter int unsigned HOLDOFF_FRAMES  = 60,
  parameter int unsigned WIN_SCORE       = 9,
  parameter int unsigned SERVE_TO_FRAMES = 300
) (
  input logic              clk_50,
  input logic              reset,
  score_event_gen_if.master port_if
);

  localparam int unsigned FRM_MAX = (HOLDOFF_FRAMES > SERVE_TO_FRAMES) ? HOLDOFF_FRAMES
                                                                       : SERVE_TO_FRAMES;
  localparam int unsigned FRM_W   = $clog2(FRM_MAX) + 1;

  ref_state_t         state_q, state_d;
  player_t            scorer_q, scorer_d;
  player_t            winner_q, winner_d;
  logic [SCORE_W-1:0] p1_cnt_q, p1_cnt_d;
  logic [SCORE_W-1:0] p2_cnt_q, p2_cnt_d;
  logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic               score1_q, score1_d;
  logic               score2_q, score2_d;
  logic               ball_freeze_q, ball_freeze_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               match_clear_q, match_clear_d;

  logic serve_evt;
  logic p1_goal;
  logic p2_goal;

  btn_sync_edge u_serve_sync (
    .clk_i   (clk_50),
    .rst_i   (reset),
    .btn_i   (port_if.serve_btn),
    .pulse_o (serve_evt)
  );

  assign p1_goal = (port_if.ball_y >= Y_W'(BOTTOM_GOAL_Y));
  assign p2_goal = (port_if.ball_y <= Y_W'(TOP_GOAL_Y));

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      scorer_q      <= P1;
      winner_q      <= P1;
      p1_cnt_q      <= '0;
      p2_cnt_q      <= '0;
      frm_cnt_q     <= '0;
      score1_q      <= 1'b0;
      score2_q      <= 1'b0;
      ball_freeze_q <= 1'b1;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      match_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scorer_q      <= scorer_d;
      winner_q      <= winner_d;
      p1_cnt_q      <= p1_cnt_d;
      p2_cnt_q      <= p2_cnt_d;
      frm_cnt_q     <= frm_cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      ball_freeze_q <= ball_freeze_d;
      serve_dir_q   <= serve_dir_d;
      game_over_q   <= game_over_d;
      match_clear_q <= match_clear_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    scorer_d      = scorer_q;
    winner_d      = winner_q;
    p1_cnt_d      = p1_cnt_q;
    p2_cnt_d      = p2_cnt_q;
    frm_cnt_d     = frm_cnt_q;
    score1_d      = 1'b0;
    score2_d      = 1'b0;
    serve_dir_d   = serve_dir_q;
    match_clear_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (serve_evt) state_d = PLAY;
      end

      // Bottom-zone goal wins when both zones overlap
      PLAY: begin
        if (port_if.frame_tick && (p1_goal || p2_goal)) begin
          scorer_d = p1_goal ? P1 : P2;
          state_d  = SCORED;
        end
      end

      SCORED: begin
        if (scorer_q == P1) begin
          score1_d    = 1'b1;
          serve_dir_d = 1'b1;
          if (p1_cnt_q < SCORE_W'(WIN_SCORE)) p1_cnt_d = p1_cnt_q + SCORE_W'(1);
        end else begin
          score2_d    = 1'b1;
          serve_dir_d = 1'b0;
          if (p2_cnt_q < SCORE_W'(WIN_SCORE)) p2_cnt_d = p2_cnt_q + SCORE_W'(1);
        end
        if ((p1_cnt_d == SCORE_W'(WIN_SCORE)) || (p2_cnt_d == SCORE_W'(WIN_SCORE))) begin
          state_d  = GAME_OVER;
          winner_d = scorer_q;
        end else begin
          state_d   = HOLDOFF;
          frm_cnt_d = '0;
        end
      end

      // Serve presses here are dropped on purpose
      HOLDOFF: begin
        if (port_if.frame_tick) begin
          if (frm_cnt_q == FRM_W'(HOLDOFF_FRAMES - 1)) begin
            state_d   = WAIT_SERVE;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
          end
        end
      end

      WAIT_SERVE: begin
        if (serve_evt) begin
          state_d = PLAY;
`ifdef SCORE_AUTOSERVE_EN
        end else if (port_if.frame_tick) begin
          if (frm_cnt_q == FRM_W'(SERVE_TO_FRAMES - 1)) begin
            state_d   = PLAY;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
          end
`endif
        end
      end

      GAME_OVER: begin
        if (serve_evt) begin
          state_d       = PLAY;
          match_clear_d = 1'b1;
          p1_cnt_d      = '0;
          p2_cnt_d      = '0;
          serve_dir_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    ball_freeze_d = (state_d != PLAY);
    game_over_d   = (state_d == GAME_OVER);
  end

  assign port_if.score1_pulse = score1_q;
  assign port_if.score2_pulse = score2_q;
  assign port_if.ball_freeze  = ball_freeze_q;
  assign port_if.serve_dir    = serve_dir_q;
  assign port_if.game_over    = game_over_q;
  assign port_if.winner       = (winner_q == P2);
  assign port_if.match_clear  = match_clear_q;

endmodule
